// File: rtl/msg_pkg.sv
// Shared constants and state encoding for the OPB message parser and the
// response framer (msg_write). The frame layout is the same in both
// directions: header, 4 address bytes, 4 data bytes, then the inverted
// header as the tail.
package msg_pkg;

    // Default frame headers; the tail of each frame is the bitwise inverse.
    localparam logic [7:0] HDR_WR  = 8'h5A;
    localparam logic [7:0] HDR_RD  = 8'h5B;
    localparam logic [7:0] TAIL_WR = ~HDR_WR;
    localparam logic [7:0] TAIL_RD = ~HDR_RD;

    // Bytes per frame: header + 4 address + 4 data + tail.
    localparam int FRAME_LEN = 10;

    // Byte positions inside a frame.
    localparam logic [3:0] BYTE_HDR  = 4'd0;
    localparam logic [3:0] BYTE_TAIL = 4'(FRAME_LEN - 1);

    // Framer states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_RD = 2'd1,
        ST_SEND    = 2'd2,
        ST_DONE    = 2'd3
    } msg_state_t;

    // Tail byte belonging to a given header.
    function automatic logic [7:0] tail_of(input logic [7:0] hdr);
        return ~hdr;
    endfunction

endpackage

// File: rtl/msg_frame_mux.sv
// Combinational byte selector: picks frame byte byte_idx out of
// {header, addr, data, ~header}. Indices past the tail return 8'h00.
module msg_frame_mux
    import msg_pkg::*;
(
    input  logic [7:0]  header,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    input  logic [3:0]  byte_idx,
    output logic [7:0]  frame_byte
);

    // Byte map: 0 header, 1-4 address MSB first, 5-8 data MSB first, 9 tail.
    always_comb begin
        frame_byte = 8'h00;
        case (byte_idx)
            4'd0:    frame_byte = header;
            4'd1:    frame_byte = addr[31:24];
            4'd2:    frame_byte = addr[23:16];
            4'd3:    frame_byte = addr[15:8];
            4'd4:    frame_byte = addr[7:0];
            4'd5:    frame_byte = data[31:24];
            4'd6:    frame_byte = data[23:16];
            4'd7:    frame_byte = data[15:8];
            4'd8:    frame_byte = data[7:0];
            4'd9:    frame_byte = tail_of(header);
            default: frame_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/msg_write.sv
// Response framer placed after the OPB message parser. Each accepted read or
// write strobe produces one 10-byte frame pushed into the UART TX FIFO.
// Reads wait RD_LATENCY cycles for the register bank before sending.
// Build option: MSG_WRITE_WR_ACK_EN -- when defined, write strobes produce an
// echo acknowledge frame; when undefined, OPB_WE alone is ignored.
module msg_write #(
    parameter int unsigned RD_LATENCY = 1,
    parameter logic [7:0]  HDR_WR     = msg_pkg::HDR_WR,
    parameter logic [7:0]  HDR_RD     = msg_pkg::HDR_RD
) (
    input  logic        OPB_CLK,
    input  logic        OPB_RST_N,
    input  logic        OPB_RE,
    input  logic        OPB_WE,
    input  logic [31:0] OPB_ADDR,
    input  logic [31:0] OPB_DO,
    input  logic [31:0] OPB_DI,
    output logic        TX_FIFO_WR,
    output logic [7:0]  TX_FIFO_DATA,
    input  logic        TX_FIFO_FULL,
    output logic        BUSY,
    output logic        DROP_PULSE,
    output logic [15:0] FRAME_CNT
);

    import msg_pkg::*;

    // Countdown start so that OPB_DI is sampled exactly RD_LATENCY cycles
    // after the strobe cycle (WAIT_RD is entered one cycle after the strobe).
    localparam logic [3:0] LAT_INIT = 4'(RD_LATENCY - 1);

    msg_state_t  state;
    logic [7:0]  hdr_reg;
    logic [31:0] addr_reg;
    logic [31:0] data_reg;
    logic [3:0]  lat_cnt;
    logic [3:0]  byte_idx;
    logic [15:0] frame_cnt_reg;
    logic        drop_reg;
    logic        we_req;
    logic        strobe_any;
    logic        send_byte;
    logic [7:0]  mux_byte;

`ifdef MSG_WRITE_WR_ACK_EN
    assign we_req = OPB_WE;
`else
    // Write strobes never start a frame in this build; the write data is
    // therefore unused and only folded into a sink signal.
    logic unused_wdata;
    assign we_req       = 1'b0;
    assign unused_wdata = ^OPB_DO;
`endif

    // Any request that would start a frame; both-high is caught separately.
    assign strobe_any = OPB_RE | we_req;
    assign send_byte  = (state == ST_SEND) && !TX_FIFO_FULL;

    msg_frame_mux u_frame_mux (
        .header     (hdr_reg),
        .addr       (addr_reg),
        .data       (data_reg),
        .byte_idx   (byte_idx),
        .frame_byte (mux_byte)
    );

    // FIFO write side follows the state directly so back-pressure stalls
    // the very byte being presented, never skipping or repeating one.
    assign TX_FIFO_WR   = send_byte;
    assign TX_FIFO_DATA = (state == ST_SEND) ? mux_byte : 8'h00;
    assign BUSY         = (state != ST_IDLE);
    assign DROP_PULSE   = drop_reg;
    assign FRAME_CNT    = frame_cnt_reg;

    // Framer state machine: request capture, read latency wait, byte
    // serialisation and end-of-frame bookkeeping.
    always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
        if (!OPB_RST_N) begin
            state         <= ST_IDLE;
            hdr_reg       <= 8'h00;
            addr_reg      <= 32'h0;
            data_reg      <= 32'h0;
            lat_cnt       <= 4'd0;
            byte_idx      <= 4'd0;
            frame_cnt_reg <= 16'd0;
            drop_reg      <= 1'b0;
        end else begin
            // Simultaneous RE/WE is illegal in IDLE; outside IDLE any new
            // request is discarded so the frame in flight is untouched.
            drop_reg <= (state == ST_IDLE) ? (OPB_RE & OPB_WE) : strobe_any;

            case (state)
                ST_IDLE: begin
                    if (OPB_RE && OPB_WE) begin
                        state <= ST_IDLE;
                    end else if (OPB_RE) begin
                        addr_reg <= OPB_ADDR;
                        hdr_reg  <= HDR_RD;
                        lat_cnt  <= LAT_INIT;
                        state    <= ST_WAIT_RD;
                    end else if (we_req) begin
                        addr_reg <= OPB_ADDR;
                        data_reg <= OPB_DO;
                        hdr_reg  <= HDR_WR;
                        state    <= ST_SEND;
                    end
                end

                ST_WAIT_RD: begin
                    if (lat_cnt == 4'd0) begin
                        data_reg <= OPB_DI;
                        state    <= ST_SEND;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end

                ST_SEND: begin
                    if (send_byte) begin
                        if (byte_idx == BYTE_TAIL) begin
                            state <= ST_DONE;
                        end else begin
                            byte_idx <= byte_idx + 4'd1;
                        end
                    end
                end

                ST_DONE: begin
                    frame_cnt_reg <= frame_cnt_reg + 16'd1;
                    byte_idx      <= BYTE_HDR;
                    state         <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msg_write.sv
// Self-checking bench for msg_write: expected frame bytes are queued when a
// request is driven and popped as the FIFO write strobe fires.
module tb_msg_write;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        re = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] di = 32'hBAD0_BAD0;
    logic        full = 1'b0;
    logic        tx_wr;
    logic [7:0]  tx_data;
    logic        busy;
    logic        drop;
    logic [15:0] frame_cnt;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];
    int nc = 0;
    int wr_cnt = 0;
    int drop_cnt = 0;
    int busy_cnt = 0;
    int frame_bytes = 0;
    int first_wr_nc = 0;
    int last_wr_nc = 0;
    int strobe_nc = 0;
    int exp_frames = 0;
    int w0, d0, b0;

    always #5 clk = ~clk;

    msg_write #(.RD_LATENCY(LAT)) dut (
        .OPB_CLK      (clk),
        .OPB_RST_N    (rst_n),
        .OPB_RE       (re),
        .OPB_WE       (we),
        .OPB_ADDR     (addr),
        .OPB_DO       (wdata),
        .OPB_DI       (di),
        .TX_FIFO_WR   (tx_wr),
        .TX_FIFO_DATA (tx_data),
        .TX_FIFO_FULL (full),
        .BUSY         (busy),
        .DROP_PULSE   (drop),
        .FRAME_CNT    (frame_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Sample outputs mid-cycle, score every FIFO write against the queue.
    always @(negedge clk) begin
        nc++;
        if (drop) drop_cnt++;
        if (busy) busy_cnt++;
        if (tx_wr) begin
            wr_cnt++;
            if (frame_bytes == 0) first_wr_nc = nc;
            last_wr_nc = nc;
            frame_bytes++;
            $display("tx byte %0d = %02h", frame_bytes - 1, tx_data);
            if (exp_q.size() == 0) begin
                chk("spurious_wr", 32'(tx_wr), 32'd0);
            end else begin
                chk("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [7:0] hdr, input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back(hdr);
        exp_q.push_back(a[31:24]);
        exp_q.push_back(a[23:16]);
        exp_q.push_back(a[15:8]);
        exp_q.push_back(a[7:0]);
        exp_q.push_back(d[31:24]);
        exp_q.push_back(d[23:16]);
        exp_q.push_back(d[15:8]);
        exp_q.push_back(d[7:0]);
        exp_q.push_back(~hdr);
        exp_frames++;
    endtask

    // One-cycle strobe; called just after a rising edge.
    task automatic send_req(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        re = r;
        we = w;
        addr = a;
        wdata = d;
        strobe_nc = nc + 1;
        frame_bytes = 0;
        tick();
        re = 1'b0;
        we = 1'b0;
        addr = $urandom;
        wdata = $urandom;
    endtask

    // Read request with OPB_DI valid only in the cycle it must be sampled.
    task automatic do_read(input logic [31:0] a, input logic [31:0] d);
        push_frame(8'h5B, a, d);
        send_req(1'b1, 1'b0, a, 32'h0);
        repeat (LAT - 1) tick();
        di = d;
        tick();
        di = 32'hBAD0_BAD0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_frames));
    endtask

    task automatic wait_bytes(input int n, input string tag);
        int k = 0;
        while (frame_bytes < n && k < 100) begin
            tick();
            k++;
        end
        chk({tag, "_reached"}, 32'(frame_bytes >= n), 32'd1);
    endtask

    initial begin
        // Reset state.
        repeat (3) tick();
        chk("rst_wr", 32'(tx_wr), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_drop", 32'(drop), 32'd0);
        chk("rst_cnt", 32'(frame_cnt), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Write request.
`ifdef MSG_WRITE_WR_ACK_EN
        push_frame(8'h5A, 32'h0000_1004, 32'hDEAD_BEEF);
        send_req(1'b0, 1'b1, 32'h0000_1004, 32'hDEAD_BEEF);
        wait_idle("wr");
        chk("wr_first_lat", 32'(first_wr_nc - strobe_nc), 32'd1);
        chk("wr_last_lat", 32'(last_wr_nc - strobe_nc), 32'd10);
        chk("wr_bytes", 32'(frame_bytes), 32'd10);
`else
        w0 = wr_cnt; d0 = drop_cnt; b0 = busy_cnt;
        send_req(1'b0, 1'b1, 32'h0000_1004, 32'hDEAD_BEEF);
        repeat (12) tick();
        chk("we_ign_wr", 32'(wr_cnt - w0), 32'd0);
        chk("we_ign_drop", 32'(drop_cnt - d0), 32'd0);
        chk("we_ign_busy", 32'(busy_cnt - b0), 32'd0);
        chk("we_ign_cnt", 32'(frame_cnt), 32'(exp_frames));
`endif
        tick();

        // Read with register latency.
        do_read(32'h0000_0020, 32'h1234_5678);
        wait_idle("rd");
        chk("rd_first_lat", 32'(first_wr_nc - strobe_nc), 32'(LAT + 1));
        chk("rd_bytes", 32'(frame_bytes), 32'd10);
        tick();

        // Back-pressure: FIFO full for 5 cycles after byte 3.
        do_read(32'hA1B2_C3D4, 32'h0F1E_2D3C);
        wait_bytes(4, "bp");
        full = 1'b1;
        repeat (5) tick();
        full = 1'b0;
        wait_idle("bp");
        chk("bp_bytes", 32'(frame_bytes), 32'd10);
        chk("bp_last_lat", 32'(last_wr_nc - strobe_nc), 32'(LAT + 1 + 9 + 5));
        tick();

        // Overlap: second read two cycles after the first is dropped.
        d0 = drop_cnt; w0 = wr_cnt;
        push_frame(8'h5B, 32'h0000_0100, 32'hCAFE_F00D);
        send_req(1'b1, 1'b0, 32'h0000_0100, 32'h0);
        tick();
        re = 1'b1;
        addr = 32'h0000_0200;
        tick();
        re = 1'b0;
        di = 32'hCAFE_F00D;
        tick();
        di = 32'hBAD0_BAD0;
        wait_idle("ovl");
        chk("ovl_drop", 32'(drop_cnt - d0), 32'd1);
        chk("ovl_wr", 32'(wr_cnt - w0), 32'd10);
        tick();

        // RE and WE together.
        w0 = wr_cnt; d0 = drop_cnt; b0 = busy_cnt;
        send_req(1'b1, 1'b1, 32'h0000_0300, 32'h5555_AAAA);
        repeat (12) tick();
        chk("both_drop", 32'(drop_cnt - d0), 32'd1);
        chk("both_wr", 32'(wr_cnt - w0), 32'd0);
        chk("both_busy", 32'(busy_cnt - b0), 32'd0);

        // Reset mid-frame after byte 4.
        do_read(32'h7777_8888, 32'h9999_AAAA);
        wait_bytes(5, "mid");
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wr", 32'(tx_wr), 32'd0);
        chk("mid_rst_data", 32'(tx_data), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_cnt", 32'(frame_cnt), 32'd0);
        exp_q.delete();
        exp_frames = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (12) tick();
        chk("mid_abandon_bytes", 32'(frame_bytes), 32'd5);
        do_read(32'h0000_0044, 32'h0BAD_CAFE);
        wait_idle("fresh");
        chk("fresh_bytes", 32'(frame_bytes), 32'd10);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/msg_write.md
Name: msg_write

Overview:
- Response framer directly downstream of the OPB message parser.
- Consumes the one-cycle OPB_RE/OPB_WE strobes with OPB_ADDR/OPB_DO from the parser, and samples the register-bank read data OPB_DI for reads.
- Serialises a 10-byte response frame into the UART TX FIFO, using the same frame format as received commands: Header, 4 address bytes MSB first, 4 data bytes MSB first, Tail = ~Header.
- Read requests return the register value; write requests return an echo acknowledge (optional, see feature).

Parameters:
- RD_LATENCY, 1, OPB_CLK cycles from the OPB_RE strobe to OPB_DI valid; legal range 1..15.
- HDR_WR, 8'h5A, header for write acknowledge frames; tail is 8'hA5.
- HDR_RD, 8'h5B, header for read response frames; tail is 8'hA4.

Ports:
- OPB_CLK  in  1  sole clock.
- OPB_RST_N  in  1  asynchronous, active-low reset.
- OPB_RE  in  1  one-cycle read strobe from the parser.
- OPB_WE  in  1  one-cycle write strobe from the parser.
- OPB_ADDR  in  32  request address, valid in the strobe cycle.
- OPB_DO  in  32  write data, valid in the strobe cycle.
- OPB_DI  in  32  register-bank read data, valid RD_LATENCY cycles after OPB_RE.
- TX_FIFO_WR  out  1  TX FIFO write enable.
- TX_FIFO_DATA  out  8  TX FIFO write byte.
- TX_FIFO_FULL  in  1  TX FIFO full.
- BUSY  out  1  high while a frame is pending or sending.
- DROP_PULSE  out  1  one-cycle pulse when a request is discarded.
- FRAME_CNT  out  16  count of completed frames; wraps at 0xFFFF→0.

Behaviour:
- Reset values: TX_FIFO_WR=0, TX_FIFO_DATA=8'h00, BUSY=0, DROP_PULSE=0, FRAME_CNT=0, state=IDLE, all capture registers 0.
- States: IDLE, WAIT_RD, SEND, DONE.
- IDLE on OPB_RE (OPB_WE low):
  - capture OPB_ADDR and header HDR_RD; load lat_cnt=RD_LATENCY-1; go to WAIT_RD.
  - In WAIT_RD, decrement lat_cnt each cycle. When lat_cnt==0, capture OPB_DI into the data register and go to SEND.
  - Net effect: OPB_DI is sampled exactly RD_LATENCY cycles after the strobe cycle.
- IDLE on OPB_WE (OPB_RE low): capture OPB_ADDR, OPB_DO and header HDR_WR; go directly to SEND in the next cycle.
- OPB_RE and OPB_WE both high in the same cycle: illegal. Pulse DROP_PULSE, capture nothing, stay in IDLE.
- Any strobe while state!=IDLE: discarded with a DROP_PULSE; the frame in progress is unaffected.
- SEND:
  - byte_idx runs 0..9.
  - TX_FIFO_WR is combinational: (state==SEND) && !TX_FIFO_FULL.
  - TX_FIFO_DATA is combinational: frame byte[byte_idx] in SEND, else 8'h00.
  - byte_idx increments only on a cycle where TX_FIFO_WR=1.
  - When TX_FIFO_FULL is high, byte_idx and data hold; no byte is skipped or duplicated.
  - When byte 9 is written, go to DONE.
- Frame byte map:
  - 0: header.
  - 1-4: ADDR[31:24], [23:16], [15:8], [7:0].
  - 5-8: DATA[31:24] .. [7:0].
  - 9: ~header.
- DONE: one cycle. FRAME_CNT+1 (wraps), byte_idx clears, return to IDLE. A strobe arriving during DONE is dropped.
- BUSY = (state!=IDLE), registered by state.
- Latency, FIFO never full:
  - write: first TX_FIFO_WR 1 cycle after the strobe, last one 10 cycles after.
  - read: first TX_FIFO_WR RD_LATENCY+1 cycles after the strobe.
- Reset asserted mid-frame: immediate return to reset values. The partial frame is abandoned and no further bytes are written.

Optional Feature:
- Macro: MSG_WRITE_WR_ACK_EN.
- Defined: write requests produce the acknowledge frame described above.
- Undefined:
  - OPB_WE is ignored entirely: no frame, no BUSY, no DROP_PULSE for OPB_WE alone, and FRAME_CNT counts reads only.
  - OPB_RE and OPB_WE high together still pulse DROP_PULSE.

Decomposition:
- Shared package msg_pkg holds HDR_WR/HDR_RD/tail constants, FRAME_LEN=10, and the state encodings; the parser uses the same package.
- One natural sub-module: msg_frame_mux, a combinational byte select from {header, addr, data, byte_idx} to TX_FIFO_DATA.

Test Plan:
- Write, FIFO empty, WR_ACK_EN defined: OPB_WE with ADDR=32'h0000_1004, DO=32'hDEAD_BEEF → bytes 5A 00 00 10 04 DE AD BE EF A5 on 10 consecutive cycles; FRAME_CNT=1.
- Read with RD_LATENCY=3: OPB_RE with ADDR=32'h0000_0020, OPB_DI=32'h1234_5678 driven only in cycle +3 → bytes 5B 00 00 00 20 12 34 56 78 A4; first write at cycle +4.
- Back-pressure: TX_FIFO_FULL held high for 5 cycles after byte 3 → exactly 10 writes, byte order intact, no duplicates.
- Overlap: second OPB_RE 2 cycles after the first → DROP_PULSE for 1 cycle; only the first frame is emitted.
- RE and WE together → DROP_PULSE, no TX_FIFO_WR, BUSY stays 0.
- Reset pulse after byte 4 → outputs at reset values; the next request produces a complete fresh frame and FRAME_CNT restarts from 0.
